// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of carry-propagate stages needed to cover width bits in chunk-bit slices.
    function automatic int calc_stages(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
interface pipe_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipe_addsub_chunk.sv
// Combinational ripple-carry slice; also exposes the carry into its MSB so the
// last slice can form the signed-overflow flag.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_carry;

    // Full-adder chain, LSB first.
    always_comb begin
        w_carry[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_carry[CHUNK];
    assign o_cmsb = w_carry[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: one CHUNK-bit carry slice per register stage, with a
// single global advance so every stage moves or freezes together.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst,
    pipe_addsub_if.slave bus
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_carry [STAGES];
    logic             r_ovf   [STAGES];

    logic             w_src_valid [STAGES];
    logic [WIDTH-1:0] w_src_a     [STAGES];
    logic [WIDTH-1:0] w_src_b     [STAGES];
    logic [WIDTH-1:0] w_src_sum   [STAGES];
    logic             w_src_carry [STAGES];
    logic [WIDTH-1:0] w_sum_nxt   [STAGES];
    logic             w_cout      [STAGES];
    logic             w_ovf_nxt   [STAGES];
    logic             w_adv;
    logic             w_unused;

    assign w_adv        = !r_valid[STAGES-1] || bus.out_ready;
    assign bus.in_ready = w_adv && !rst;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * CHUNK;
            localparam int W  = (k == STAGES - 1) ? (WIDTH - LO) : CHUNK;
            localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - W)) << LO;

            logic [W-1:0]     w_chunk_sum;
            logic [WIDTH-1:0] w_chunk_ext;
            logic             w_cmsb;

            // Stage 0 takes the raw beat; subtraction becomes a + ~b + ~borrow.
            if (k == 0) begin : g_head
                assign w_src_valid[k] = bus.in_valid;
                assign w_src_a[k]     = bus.in_a;
                assign w_src_b[k]     = (bus.in_sub == OP_SUB) ? ~bus.in_b : bus.in_b;
                assign w_src_carry[k] = (bus.in_sub == OP_SUB) ? ~bus.in_cin : bus.in_cin;
                assign w_src_sum[k]   = '0;
            end else begin : g_body
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_a[k]     = r_a[k-1];
                assign w_src_b[k]     = r_b[k-1];
                assign w_src_carry[k] = r_carry[k-1];
                assign w_src_sum[k]   = r_sum[k-1];
            end

            addsub_chunk #(.CHUNK(W)) u_chunk (
                .i_a    (w_src_a[k][LO +: W]),
                .i_b    (w_src_b[k][LO +: W]),
                .i_cin  (w_src_carry[k]),
                .o_sum  (w_chunk_sum),
                .o_cout (w_cout[k]),
                .o_cmsb (w_cmsb)
            );

            assign w_chunk_ext  = WIDTH'(w_chunk_sum);
            assign w_sum_nxt[k] = (w_src_sum[k] & ~MASK) | (w_chunk_ext << LO);
            // Overflow only matters in the last stage, where this slice holds the MSB.
            assign w_ovf_nxt[k] = w_cout[k] ^ w_cmsb;
        end
    endgenerate

    // Stage registers: flushed by reset, otherwise all load together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_ovf[k]   <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_src_valid[k];
                r_a[k]     <= w_src_a[k];
                r_b[k]     <= w_src_b[k];
                r_sum[k]   <= w_sum_nxt[k];
                r_carry[k] <= w_cout[k];
                r_ovf[k]   <= w_ovf_nxt[k];
            end
        end
    end

    // Operand bits already consumed and overflow of non-final stages are dead ends.
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^r_a[k]) ^ (^r_b[k]) ^ r_ovf[k];
        end
    end

    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out_sum   = r_sum[STAGES-1];
    assign bus.out_cout  = r_carry[STAGES-1];
    assign bus.out_ovf   = r_ovf[STAGES-1];

endmodule
